// File: rtl/falafel_pkg.sv
// Shared types for the header load/store unit: request/response structs and op encodings.
package falafel_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] LOAD_HEADER  = 2'd0;
  localparam logic [1:0] STORE_HEADER = 2'd1;
  localparam logic [1:0] EDIT_NEXT    = 2'd2;

  typedef struct packed {
    logic [DATA_W-1:0] size;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] next_addr;
  } header_data_t;

  typedef struct packed {
    logic         val;
    logic [1:0]   lsu_op;
    header_data_t header_data;
  } header_req_t;

  typedef struct packed {
    logic         val;
    header_data_t header_data;
  } header_rsp_t;

  // Byte address of the word that follows a header base; wraps modulo 2^DATA_W.
  function automatic logic [DATA_W-1:0] word_after(input logic [DATA_W-1:0] base,
                                                   input int unsigned       off);
    return base + DATA_W'(off);
  endfunction

endpackage

// File: rtl/header_lsu_if.sv
// Bundle of the core request/response and memory bus seen by header_lsu.
interface header_lsu_if;
  import falafel_pkg::*;

  header_req_t       req;
  logic              ready;
  header_rsp_t       rsp;
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  // master: the LSU view (drives the memory bus and core response)
  modport master (
    input  req, mem_gnt, mem_rvalid, mem_rdata,
    output ready, rsp, mem_req, mem_we, mem_addr, mem_wdata
  );

  // slave: the core + memory environment around the LSU
  modport slave (
    output req, mem_gnt, mem_rvalid, mem_rdata,
    input  ready, rsp, mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/header_lsu.sv
// Header load/store unit: reads or writes the {size, next_addr} pair of a block header,
// one memory access at a time, and returns a single-cycle response to the core.
module header_lsu
  import falafel_pkg::*;
#(
  parameter int unsigned NEXT_OFFSET = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  header_req_t       req_from_core_i,
  output logic              lsu_ready_o,
  output header_rsp_t       rsp_to_core_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic [2:0] {
    IDLE, RD_SIZE, RD_SIZE_W, RD_NEXT, RD_NEXT_W, WR_SIZE, WR_NEXT, RSP
  } state_e;

  state_e            state_q, state_d;
  header_data_t      data_q, data_d;
  logic [DATA_W-1:0] next_word_addr;

  assign next_word_addr = word_after(data_q.addr, NEXT_OFFSET);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // All outputs decode from state only, so reset silences the bus with no clock.
  always_comb begin
    state_d       = state_q;
    data_d        = data_q;
    lsu_ready_o   = 1'b0;
    rsp_to_core_o = '0;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;
    case (state_q)
      IDLE: begin
        lsu_ready_o = 1'b1;
        if (req_from_core_i.val) begin
          data_d = req_from_core_i.header_data;
          case (req_from_core_i.lsu_op)
            LOAD_HEADER:  state_d = RD_SIZE;
            STORE_HEADER: state_d = WR_SIZE;
            EDIT_NEXT:    state_d = WR_NEXT;
            default:      state_d = RSP;
          endcase
        end
      end
      RD_SIZE: begin
        mem_req_o  = 1'b1;
        mem_addr_o = data_q.addr;
        if (mem_gnt_i) state_d = RD_SIZE_W;
      end
      RD_SIZE_W: begin
        if (mem_rvalid_i) begin
          data_d.size = mem_rdata_i;
          state_d     = RD_NEXT;
        end
      end
      RD_NEXT: begin
        mem_req_o  = 1'b1;
        mem_addr_o = next_word_addr;
        if (mem_gnt_i) state_d = RD_NEXT_W;
      end
      RD_NEXT_W: begin
        if (mem_rvalid_i) begin
          data_d.next_addr = mem_rdata_i;
          state_d          = RSP;
        end
      end
      WR_SIZE: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = data_q.addr;
        mem_wdata_o = data_q.size;
        if (mem_gnt_i) state_d = WR_NEXT;
      end
      WR_NEXT: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = next_word_addr;
        mem_wdata_o = data_q.next_addr;
        if (mem_gnt_i) state_d = RSP;
      end
      RSP: begin
        rsp_to_core_o.val         = 1'b1;
        rsp_to_core_o.header_data = data_q;
        state_d                   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/header_lsu.md
HEADER_LSU -- requirements
Module: header_lsu

Interface
REQ-001 SHALL have parameter NEXT_OFFSET, default DATA_W/8, giving the byte offset of the next_addr word from the header base address.
REQ-002 SHALL have port clk_i, input, 1, the single clock.
REQ-003 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port req_from_core_i, input, header_req_t, the metadata request from core: val, lsu_op, header_data{size, addr, next_addr}.
REQ-005 SHALL have port lsu_ready_o, output, 1, high when a new request can be accepted.
REQ-006 SHALL have port rsp_to_core_o, output, header_rsp_t, the metadata response: val, header_data{size, addr, next_addr}.
REQ-007 SHALL have port mem_req_o, output, 1, memory request valid.
REQ-008 SHALL have port mem_we_o, output, 1, memory write enable.
REQ-009 SHALL have port mem_addr_o, output, DATA_W, memory byte address.
REQ-010 SHALL have port mem_wdata_o, output, DATA_W, memory write data.
REQ-011 SHALL have port mem_gnt_i, input, 1, memory grant.
REQ-012 SHALL have port mem_rvalid_i, input, 1, read data valid.
REQ-013 SHALL have port mem_rdata_i, input, DATA_W, read data.

Function
REQ-014 SHALL accept a request on a rising edge where req_from_core_i.val=1 and lsu_ready_o=1, registering the op and header_data.
REQ-015 SHALL drive lsu_ready_o=1 only in IDLE.
REQ-016 SHALL implement these states:
- IDLE
- RD_SIZE, RD_SIZE_W, RD_NEXT, RD_NEXT_W
- WR_SIZE, WR_NEXT
- RSP
REQ-017 SHALL handle LOAD_HEADER as: IDLE->RD_SIZE->RD_SIZE_W->RD_NEXT->RD_NEXT_W->RSP->IDLE.
- Reads at addr, then at addr+NEXT_OFFSET.
- Captured data goes to size and next_addr.
REQ-018 SHALL handle STORE_HEADER as: IDLE->WR_SIZE->WR_NEXT->RSP->IDLE.
- Writes size to addr, then next_addr to addr+NEXT_OFFSET.
REQ-019 SHALL handle EDIT_NEXT as: IDLE->WR_NEXT->RSP->IDLE.
- Writes only next_addr to addr+NEXT_OFFSET.
REQ-020 SHALL treat any other lsu_op value as illegal: IDLE->RSP with no memory access, echoing the request fields.
REQ-021 SHALL follow these memory handshake rules:
- In each request state, mem_req_o=1 and address/we/wdata are held stable until mem_gnt_i=1.
- The transition occurs on the grant edge.
- In wait states, remain until mem_rvalid_i=1.
- At most one read outstanding.
REQ-022 SHALL assert rsp_to_core_o.val for exactly one cycle in RSP, with no backpressure.
- header_data.addr = request addr.
- For stores and EDIT_NEXT, size/next_addr echo the request; for EDIT_NEXT, size echoes the request size.
REQ-023 SHALL meet these minimum latencies, measured from the accept edge to the cycle rsp val is high, with gnt in the first request cycle and rvalid one cycle later: LOAD 5, STORE 3, EDIT_NEXT 2, illegal 1.
REQ-024 SHALL compute address arithmetic modulo 2^DATA_W; addr+NEXT_OFFSET wraps silently.
REQ-025 SHALL ignore mem_rvalid_i outside the wait states.
REQ-026 SHALL drive mem_req_o=0 and rsp val=0 in IDLE.

Reset
REQ-027 SHALL, while rst_ni=0, force state IDLE and drive:
- mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0
- rsp_to_core_o all zero
- lsu_ready_o=1
REQ-028 SHALL abandon an in-flight transaction on reset mid-operation, dropping mem_req_o immediately and producing no response.

Structure
REQ-029 SHALL take DATA_W, header_req_t, header_rsp_t and the lsu_op encodings (LOAD_HEADER=0, STORE_HEADER=1, EDIT_NEXT=2) from falafel_pkg; the state enum is local.
REQ-030 SHALL be a single module with no sub-modules.

Verification
REQ-031 SHALL cover LOAD at addr 0x100, memory holding 0x40@0x100 and 0x200@0x104, gnt immediate, rvalid +1 -> reads at 0x100 then 0x104; rsp val 5 cycles after accept with size=0x40, next_addr=0x200, addr=0x100.
REQ-032 SHALL cover STORE size=0x20, next_addr=0x300, addr=0x180 with gnt held low 3 cycles on the first write -> addr/wdata stable throughout; writes (0x180, 0x20) then (0x184, 0x300); single rsp pulse.
REQ-033 SHALL cover EDIT_NEXT addr=0x200, next_addr=0x0 -> exactly one write (0x204, 0x0); no access at 0x200; rsp 2 cycles after accept.
REQ-034 SHALL cover lsu_op=3 -> no mem_req_o; rsp next cycle echoing all fields; lsu_ready_o back high.
REQ-035 SHALL cover rst_ni pulsed low while in RD_NEXT_W -> mem_req_o=0 asynchronously; no rsp; a subsequent LOAD completes normally.
REQ-036 SHALL cover addr=0xFFFFFFFC with DATA_W=32 and STORE -> second write at 0x00000000.
